// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) built around one shared WIDTH+1-bit adder.
// Flow: operand negation, radix-2 restoring iterations, then one result sign fix.
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_dz,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, ITER, FIX, DONE} state_t;

   state_t           state_reg, state_next;
   logic [1:0]       op_reg, op_next;
   logic             sa_reg, sa_next;
   logic             sb_reg, sb_next;
   logic             bypass_reg, bypass_next;
   logic             dz_reg, dz_next;
   logic [WIDTH-1:0] quo_reg, quo_next;
   logic [WIDTH-1:0] rem_reg, rem_next;
   logic [WIDTH-1:0] dvs_reg, dvs_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic [CW-1:0]    count_reg, count_next;

   logic [WIDTH:0]   add_a, add_b, add_sum;
   logic             add_cin, add_cout, add_unused;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] fix_val;
   logic             fix_neg;

   // Shared adder: sum = A + B + Cin, carry-out of the WIDTH+1-bit sum flags rem >= divisor.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
   assign add_unused = add_sum[WIDTH];

   assign in_ready   = (state_reg == IDLE);
   assign busy       = (state_reg != IDLE);
   assign out_valid  = (state_reg == DONE);
   assign out_result = result_reg;
   assign out_dz     = dz_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         op_reg     <= '0;
         sa_reg     <= 1'b0;
         sb_reg     <= 1'b0;
         bypass_reg <= 1'b0;
         dz_reg     <= 1'b0;
         quo_reg    <= '0;
         rem_reg    <= '0;
         dvs_reg    <= '0;
         result_reg <= '0;
         count_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         sa_reg     <= sa_next;
         sb_reg     <= sb_next;
         bypass_reg <= bypass_next;
         dz_reg     <= dz_next;
         quo_reg    <= quo_next;
         rem_reg    <= rem_next;
         dvs_reg    <= dvs_next;
         result_reg <= result_next;
         count_reg  <= count_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      sa_next     = sa_reg;
      sb_next     = sb_reg;
      bypass_next = bypass_reg;
      dz_next     = dz_reg;
      quo_next    = quo_reg;
      rem_next    = rem_reg;
      dvs_next    = dvs_reg;
      result_next = result_reg;
      count_next  = count_reg;
      add_a       = '0;
      add_b       = '0;
      add_cin     = 1'b0;
      rem_shift   = {rem_reg, quo_reg[WIDTH-1]};
      fix_val     = op_reg[1] ? rem_reg : quo_reg;
      // Only the selected result is negated, so a single adder pass suffices in FIX.
      fix_neg     = ~op_reg[0] & (op_reg[1] ? sa_reg : (sa_reg ^ sb_reg));

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               op_next     = in_op;
               sa_next     = ~in_op[0] & in_a[WIDTH-1];
               sb_next     = ~in_op[0] & in_b[WIDTH-1];
               quo_next    = in_a;
               dvs_next    = in_b;
               dz_next     = 1'b0;
               bypass_next = 1'b0;
               if (in_b == '0) begin
                  quo_next    = '1;
                  rem_next    = in_a;
                  dz_next     = 1'b1;
                  bypass_next = 1'b1;
                  state_next  = FIX;
               end else if (!in_op[0] && in_a == MIN && in_b == '1) begin
                  quo_next    = MIN;
                  rem_next    = '0;
                  bypass_next = 1'b1;
                  state_next  = FIX;
               end else begin
                  state_next  = NEG_A;
               end
            end
         end
         NEG_A: begin
            add_b   = ~{1'b0, quo_reg};
            add_cin = 1'b1;
            if (sa_reg) quo_next = add_sum[WIDTH-1:0];
            state_next = NEG_B;
         end
         NEG_B: begin
            add_b   = ~{1'b0, dvs_reg};
            add_cin = 1'b1;
            if (sb_reg) dvs_next = add_sum[WIDTH-1:0];
            count_next = '0;
            rem_next   = '0;
            state_next = ITER;
         end
         ITER: begin
            add_a      = rem_shift;
            add_b      = ~{1'b0, dvs_reg};
            add_cin    = 1'b1;
            rem_next   = add_cout ? add_sum[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            quo_next   = {quo_reg[WIDTH-2:0], add_cout};
            count_next = count_reg + CW'(1);
            if (count_reg == CW'(WIDTH - 1)) state_next = FIX;
         end
         FIX: begin
            add_b       = ~{1'b0, fix_val};
            add_cin     = 1'b1;
            result_next = (fix_neg && !bypass_reg) ? add_sum[WIDTH-1:0] : fix_val;
            state_next  = DONE;
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (flush && state_reg != IDLE) begin
         state_next  = IDLE;
         result_next = result_reg;
      end
   end
endmodule
